// File: rtl/usb_ulpi_state_machine.sv
// ULPI link-side controller: filters PHY RX CMD bytes on receive and serialises a
// buffered packet (payload + CRC) onto the ULPI bus on transmit, all in the clk domain.
module usb_ulpi_state_machine #(
  parameter int DATA_BYTES = 64,
  parameter int CRC_BYTES  = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  ulpi_clk,
  input  logic                                  dir,
  input  logic                                  nxt,
  input  logic [7:0]                            data_in,
  input  logic                                  shift_out,
  input  logic [(DATA_BYTES+CRC_BYTES)*8-1:0]   internal_data_in,
  output logic [7:0]                            data_out,
  output logic                                  stp,
  output logic                                  new_byte,
  output logic [7:0]                            internal_data_out
);

  localparam int TOTAL = DATA_BYTES + CRC_BYTES;
  localparam int IDX_W = $clog2(TOTAL);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

  typedef enum logic [1:0] {IDLE, RX_TURN, RX, TX} state_t;

  state_t           state_reg;
  logic             sync1_reg;
  logic             sync2_reg;
  logic             prev_reg;
  logic             tick;
  logic             load;
  logic [IDX_W-1:0] idx_reg;
  logic             stp_reg;
  logic             new_byte_reg;
  logic [7:0]       rx_byte_reg;
  logic [7:0]       in_bytes [TOTAL];
  logic [7:0]       pkt_reg  [TOTAL];

  // ulpi_clk is only data here; a rising edge becomes a single-cycle tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= ulpi_clk;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign tick = sync2_reg & ~prev_reg;

  // An RX turnaround in IDLE takes priority over a transmit request.
  assign load = (state_reg == IDLE) && !(tick && dir) && shift_out;

  generate
    for (genvar gi = 0; gi < TOTAL; gi++) begin : g_pkt
      assign in_bytes[gi] = internal_data_in[gi*8 +: 8];

      always_ff @(posedge clk) begin
        if (load) begin
          pkt_reg[gi] <= in_bytes[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      stp_reg      <= 1'b0;
      new_byte_reg <= 1'b0;
      rx_byte_reg  <= 8'h00;
    end else begin
      case (state_reg)
        IDLE: begin
          new_byte_reg <= 1'b0;
          stp_reg      <= 1'b0;
          if (tick && dir) begin
            state_reg <= RX_TURN;
          end else if (load) begin
            idx_reg   <= '0;
            state_reg <= TX;
          end
        end

        RX_TURN: begin
          new_byte_reg <= 1'b0;
          if (tick) begin
            state_reg <= dir ? RX : IDLE;
          end
        end

        RX: begin
          if (tick) begin
            if (!dir) begin
              new_byte_reg <= 1'b0;
              state_reg    <= IDLE;
            end else if (nxt) begin
              rx_byte_reg  <= data_in;
              new_byte_reg <= 1'b1;
            end else begin
              new_byte_reg <= 1'b0;
            end
          end
        end

        TX: begin
          new_byte_reg <= 1'b0;
          if (tick) begin
            if (dir) begin
              stp_reg   <= 1'b0;
              idx_reg   <= '0;
              state_reg <= RX_TURN;
            end else if (stp_reg) begin
              stp_reg   <= 1'b0;
              idx_reg   <= '0;
              state_reg <= IDLE;
            end else if (!shift_out) begin
              // The last byte stays on the bus for a full tick before stp.
              if (idx_reg == LAST_IDX) begin
                stp_reg <= 1'b1;
              end else begin
                idx_reg <= idx_reg + 1'b1;
              end
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign data_out          = (state_reg == TX && !stp_reg) ? pkt_reg[idx_reg] : 8'h00;
  assign stp               = stp_reg;
  assign new_byte          = new_byte_reg;
  assign internal_data_out = rx_byte_reg;

endmodule

// File: tb/tb_usb_ulpi_state_machine.sv
// Directed bench for usb_ulpi_state_machine: receive filtering, transmit
// serialisation with stp, transmit abort by the PHY, and reset mid-transmit.
module tb_usb_ulpi_state_machine;

  logic         clk;
  logic         rst;
  logic         ulpi_clk;
  logic         dir;
  logic         nxt;
  logic [7:0]   data_in;
  logic         shift_out;
  logic [527:0] internal_data_in;
  logic [7:0]   data_out;
  logic         stp;
  logic         new_byte;
  logic [7:0]   internal_data_out;

  int total_cnt  = 0;
  int passed_cnt = 0;
  int failed_cnt = 0;

  usb_ulpi_state_machine #(.DATA_BYTES(64), .CRC_BYTES(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .ulpi_clk          (ulpi_clk),
    .dir               (dir),
    .nxt               (nxt),
    .data_in           (data_in),
    .shift_out         (shift_out),
    .internal_data_in  (internal_data_in),
    .data_out          (data_out),
    .stp               (stp),
    .new_byte          (new_byte),
    .internal_data_out (internal_data_out)
  );

  // clk posedges at 3+6k ns; ulpi_clk rises at 12+24k ns, never on a clk edge.
  initial begin
    clk = 1'b0;
    forever #3 clk = ~clk;
  end

  initial begin
    ulpi_clk = 1'b0;
    forever #12 ulpi_clk = ~ulpi_clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) passed_cnt++;
    else begin
      failed_cnt++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  // Drive the bus just after a ulpi_clk rise; the DUT acts about 15 ns later,
  // and the task returns at rise+20 ns for checking.
  task automatic step(input logic d, input logic n, input logic [7:0] din, input logic so);
    @(posedge ulpi_clk);
    #1;
    dir       = d;
    nxt       = n;
    data_in   = din;
    shift_out = so;
    #19;
  endtask

  initial begin
    rst              = 1'b1;
    dir              = 1'b0;
    nxt              = 1'b0;
    data_in          = 8'h00;
    shift_out        = 1'b0;
    internal_data_in = {33{8'hAA, 8'hBB}};

    // Reset
    @(posedge clk);
    #1 rst = 1'b0;
    check("reset new_byte", {7'd0, new_byte}, 8'h00);
    check("reset stp", {7'd0, stp}, 8'h00);
    check("reset data_out", data_out, 8'h00);
    check("reset internal_data_out", internal_data_out, 8'h00);

    // RX CMD only
    step(1'b1, 1'b0, 8'hFF, 1'b0);
    check("rxcmd turn new_byte", {7'd0, new_byte}, 8'h00);
    step(1'b1, 1'b0, 8'hFF, 1'b0);
    check("rxcmd ff1 new_byte", {7'd0, new_byte}, 8'h00);
    step(1'b1, 1'b0, 8'hFF, 1'b0);
    check("rxcmd ff2 new_byte", {7'd0, new_byte}, 8'h00);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("rxcmd 00 new_byte", {7'd0, new_byte}, 8'h00);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("rxcmd exit new_byte", {7'd0, new_byte}, 8'h00);
    check("rxcmd internal_data_out", internal_data_out, 8'h00);

    // RX CMD then a byte without nxt
    step(1'b1, 1'b0, 8'h10, 1'b0);
    step(1'b1, 1'b0, 8'h10, 1'b0);
    step(1'b1, 1'b0, 8'hFF, 1'b0);
    check("nonxt new_byte", {7'd0, new_byte}, 8'h00);
    check("nonxt internal_data_out", internal_data_out, 8'h00);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Single data byte; nxt on the turnaround tick must not capture
    step(1'b1, 1'b1, 8'h55, 1'b0);
    check("turn nxt new_byte", {7'd0, new_byte}, 8'h00);
    check("turn nxt internal_data_out", internal_data_out, 8'h00);
    step(1'b1, 1'b0, 8'h10, 1'b0);
    check("single rxcmd new_byte", {7'd0, new_byte}, 8'h00);
    step(1'b1, 1'b1, 8'hAA, 1'b0);
    check("single new_byte", {7'd0, new_byte}, 8'h01);
    check("single internal_data_out", internal_data_out, 8'hAA);
    step(1'b1, 1'b0, 8'h10, 1'b0);
    check("single hold new_byte", {7'd0, new_byte}, 8'h00);
    check("single hold internal_data_out", internal_data_out, 8'hAA);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("single exit new_byte", {7'd0, new_byte}, 8'h00);
    check("single exit internal_data_out", internal_data_out, 8'hAA);

    // Multiple data bytes; shift_out during RX must be ignored
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h10, 1'b0);
    step(1'b1, 1'b1, 8'hFF, 1'b0);
    check("multi1 new_byte", {7'd0, new_byte}, 8'h01);
    check("multi1 internal_data_out", internal_data_out, 8'hFF);
    step(1'b1, 1'b1, 8'hAA, 1'b1);
    check("multi2 new_byte", {7'd0, new_byte}, 8'h01);
    check("multi2 internal_data_out", internal_data_out, 8'hAA);
    check("rx shift_out data_out", data_out, 8'h00);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("multi exit new_byte", {7'd0, new_byte}, 8'h00);
    check("multi exit data_out", data_out, 8'h00);

    // Transmit {33{AA,BB}}: byte 0 = BB
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("tx byte0 data_out", data_out, 8'hBB);
    check("tx byte0 stp", {7'd0, stp}, 8'h00);
    for (int k = 1; k < 66; k++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      check($sformatf("tx byte%0d data_out", k), data_out, (k % 2 == 1) ? 8'hAA : 8'hBB);
      check($sformatf("tx byte%0d stp", k), {7'd0, stp}, 8'h00);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("tx stp", {7'd0, stp}, 8'h01);
    check("tx stp data_out", data_out, 8'h00);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("tx end stp", {7'd0, stp}, 8'h00);
    check("tx end data_out", data_out, 8'h00);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("tx idle data_out", data_out, 8'h00);

    // Transmit aborted by dir=1, then receive
    for (int k = 0; k < 66; k++) internal_data_in[k*8 +: 8] = 8'(k + 1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("abort byte0 data_out", data_out, 8'h01);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("abort byte1 data_out", data_out, 8'h02);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("abort data_out", data_out, 8'h00);
    check("abort stp", {7'd0, stp}, 8'h00);
    step(1'b1, 1'b1, 8'h77, 1'b0);
    check("abort turn new_byte", {7'd0, new_byte}, 8'h00);
    step(1'b1, 1'b1, 8'h66, 1'b0);
    check("abort rx new_byte", {7'd0, new_byte}, 8'h01);
    check("abort rx internal_data_out", internal_data_out, 8'h66);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("abort exit new_byte", {7'd0, new_byte}, 8'h00);

    // Reset in the middle of a transmit
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("rsttx byte0 data_out", data_out, 8'h01);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("rsttx byte1 data_out", data_out, 8'h02);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("rsttx data_out", data_out, 8'h00);
    check("rsttx stp", {7'd0, stp}, 8'h00);
    check("rsttx new_byte", {7'd0, new_byte}, 8'h00);
    check("rsttx internal_data_out", internal_data_out, 8'h00);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("rsttx idle data_out", data_out, 8'h00);

    $display("%0d/%0d checks passed", passed_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/usb_ulpi_state_machine.md
Name: usb_ulpi_state_machine

Overview:
ULPI link-side controller between a USB PHY (ULPI byte bus) and the internal packet logic. On receive, it filters PHY RX CMD bytes and forwards data bytes with a new_byte strobe. On transmit, it serialises a 66-byte packet buffer (64 data + 2 CRC) onto the ULPI data bus, least-significant byte first, and then asserts stp. Everything runs on the single system clock clk; the PHY's 60 MHz ulpi_clk is treated as a sampled input, not a clock.

Parameters:
DATA_BYTES, 64, payload bytes per transmit packet
CRC_BYTES, 2, trailing CRC bytes per transmit packet

Ports:
clk  input  1  system clock (about 180 MHz, at least 3x ulpi_clk); the only clock
rst  input  1  synchronous, active-high reset
ulpi_clk  input  1  PHY clock, sampled as data through a 2-flop synchroniser
dir  input  1  ULPI bus direction; 1 = PHY drives data_in
nxt  input  1  ULPI next; during receive, 1 = current byte is packet data
data_in  input  8  ULPI data from the PHY
shift_out  input  1  transmit request; loads internal_data_in
internal_data_in  input  (DATA_BYTES+CRC_BYTES)*8 = 528  transmit packet; byte k = bits [8k+7:8k]
data_out  output  8  ULPI data to the PHY
stp  output  1  ULPI stop; ends a transmit
new_byte  output  1  received data byte valid
internal_data_out  output  8  last received data byte

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; data_out=0x00, stp=0, new_byte=0, internal_data_out=0x00; byte index=0; synchroniser flops cleared.
- ulpi tick: a one-clk-cycle pulse when the synchronised ulpi_clk is 1 and its previous sample was 0. Latency from a ulpi_clk rising edge to the tick is 2-3 clk cycles.
- All ULPI decisions (dir, nxt, data_in) are sampled in the clk cycle of the tick.
- States: IDLE, RX_TURN, RX, TX.
- IDLE:
  - On a tick with dir=1: go to RX_TURN.
  - Else, when shift_out=1 at any clk edge: copy internal_data_in into the packet register, set index=0, go to TX.
- RX_TURN: the turnaround tick. The next tick goes to RX if dir=1, else to IDLE. No byte is captured in RX_TURN.
- RX, on each tick:
  - dir=0: new_byte=0, go to IDLE.
  - dir=1 and nxt=0 (RX CMD): the byte is discarded and new_byte=0.
  - dir=1 and nxt=1: internal_data_out<=data_in and new_byte=1.
  - new_byte therefore holds for one ulpi period, until the next tick re-evaluates it. Consecutive data bytes keep new_byte=1 while internal_data_out updates.
  - internal_data_out holds its value between data bytes.
- TX:
  - data_out = packet byte[index] combinationally from the register, so byte 0 appears the clk cycle after the load.
  - index increments on each tick for which shift_out=0. Ticks while shift_out is still asserted do not advance.
  - After byte 65 has been presented for one tick interval, the next tick sets stp=1 and data_out=0x00. stp stays 1 until the following tick, then returns to 0 and the state returns to IDLE.
  - nxt is ignored in TX.
  - If a tick sees dir=1 during TX: abort, stp=0, data_out=0x00, go to RX_TURN.
- shift_out is ignored in RX_TURN, RX and TX; there is no queuing.
- new_byte is forced to 0 outside RX.
- data_out is 0x00 outside TX.
- rst in any state returns to the reset values on the next clk edge, aborting any RX or TX.

Test Plan:
- Reset: rst=1 for 1 clk -> new_byte=0, stp=0, data_out=0x00.
- RX CMD only: dir=1, data_in=0xFF, nxt=0 for 2 ulpi periods, then 0x00 -> new_byte stays 0 throughout; after dir=0 the state is IDLE.
- RX CMD then byte without nxt: 0x10 then 0xFF, nxt=0 -> new_byte=0.
- Single data byte: dir=1, RX CMD 0x10, then nxt=1 with data_in=0xAA -> 2.5 clk after that ulpi edge, new_byte=1 and internal_data_out=0xAA; dir=0 -> new_byte=0.
- Multiple data bytes: nxt=1 with 0xFF then 0xAA on consecutive ulpi edges -> new_byte=1 with internal_data_out 0xFF, then 0xAA.
- Transmit: internal_data_in = {33{0xAA,0xBB}}, shift_out pulsed for one ulpi period -> data_out=0xBB at the next ulpi edge; after each following edge data_out alternates AA,BB,... for 65 further bytes; then stp=1 for one ulpi period with data_out=0x00; then IDLE.
